// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder block.
package adder_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int MAX_NIBBLES = 8;
  localparam int IDX_W       = $clog2(MAX_NIBBLES);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder built from four full-adder bits.
module nibble_add4
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);

  logic [NIBBLE_W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_adder.sv
// W-bit add/subtract performed one nibble per clock through a single 4-bit adder,
// with valid/ready handshakes on operand input and result output.
module serial_nibble_adder
  import adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c_out
);

  state_t                state;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic                  carry_q;
  idx_t                  idx;
  logic [NIBBLE_W-1:0]   nib_a;
  logic [NIBBLE_W-1:0]   nib_b;
  logic [NIBBLE_W-1:0]   nib_s;
  logic                  nib_c;
  logic                  last_nib;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == idx_t'(n)) begin
        nib_a = a_q[NIBBLE_W*n +: NIBBLE_W];
        nib_b = b_q[NIBBLE_W*n +: NIBBLE_W];
      end
    end
  end

  assign last_nib = (idx == idx_t'(NIBBLES - 1));

  nibble_add4 u_add (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .s     (nib_s),
    .c_out (nib_c)
  );

  // Operand registers hold data only and are left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= sub ? 1'b1 : c_in;
            idx      <= '0;
            s        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == idx_t'(n)) s[NIBBLE_W*n +: NIBBLE_W] <= nib_s;
          end
          carry_q <= nib_c;
          idx     <= idx + idx_t'(1);
          if (last_nib) begin
            c_out     <= nib_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder at NIBBLES = 4, 1 and 8 against an arithmetic reference.
module tb_serial_nibble_adder;

  logic        clk;
  logic        rst;
  logic        iv   [3];
  logic        ordy [3];
  logic        ci   [3];
  logic        sb   [3];
  logic [31:0] av   [3];
  logic [31:0] bv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        co   [3];
  logic [15:0] s0;
  logic [3:0]  s1;
  logic [31:0] s2;

  int checks = 0;
  int errors = 0;

  serial_nibble_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][15:0]), .b(bv[0][15:0]), .c_in(ci[0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .s(s0), .c_out(co[0])
  );

  serial_nibble_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][3:0]), .b(bv[1][3:0]), .c_in(ci[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .s(s1), .c_out(co[1])
  );

  serial_nibble_adder #(.NIBBLES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .c_in(ci[2]), .sub(sb[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .s(s2), .c_out(co[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int nib_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  function automatic logic [31:0] get_s(input int d);
    case (d)
      0:       return {16'h0, s0};
      1:       return {28'h0, s1};
      default: return s2;
    endcase
  endfunction

  // Reference: {c_out, s} as plain integer arithmetic on W-bit unsigned operands.
  function automatic longint unsigned ref_sum(input int w, input logic [31:0] x, input logic [31:0] y,
                                              input logic cin, input logic sbt);
    longint unsigned mask;
    longint unsigned xa;
    longint unsigned yb;
    mask = (64'd1 << w) - 64'd1;
    xa   = longint'(x) & mask;
    yb   = longint'(y) & mask;
    if (sbt) return xa + ((~yb) & mask) + 64'd1;
    else     return xa + yb + longint'(cin);
  endfunction

  task automatic run_op(input int d, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xci, input logic xsb,
                        output logic [31:0] rs, output logic rc, output int lat, output int busy);
    int n;
    n = 0;
    av[d] = xa; bv[d] = xb; ci[d] = xci; sb[d] = xsb; ordy[d] = 1'b1; iv[d] = 1'b1;
    while (!ir[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ir[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait dut%0d in_ready got %b required 1", d, ir[d]);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat  = 1;
    busy = 1;
    while (!ov[d] && lat < 50) begin
      if (!ir[d]) busy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!ir[d]) busy++;
    rs = get_s(d);
    rc = co[d];
    @(posedge clk); #1;
    if (!ir[d]) busy++;
  endtask

  task automatic check_op(input string name, input int d, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xci, input logic xsb);
    logic [31:0]     rs;
    logic            rc;
    int              lat;
    int              busy;
    int              w;
    longint unsigned r;
    logic [31:0]     es;
    logic            ec;
    w  = 4 * nib_of(d);
    r  = ref_sum(w, xa, xb, xci, xsb);
    es = 32'(r & ((64'd1 << w) - 64'd1));
    ec = r[w];
    run_op(d, xa, xb, xci, xsb, rs, rc, lat, busy);
    checks++;
    if (rs !== es) begin
      errors++;
      $display("FAIL %s_s dut%0d a=%h b=%h got %h required %h", name, d, xa, xb, rs, es);
    end
    checks++;
    if (rc !== ec) begin
      errors++;
      $display("FAIL %s_cout dut%0d a=%h b=%h got %b required %b", name, d, xa, xb, rc, ec);
    end
    checks++;
    if (lat != nib_of(d) + 1) begin
      errors++;
      $display("FAIL %s_latency dut%0d got %0d required %0d", name, d, lat, nib_of(d) + 1);
    end
    checks++;
    if (busy != nib_of(d) + 2) begin
      errors++;
      $display("FAIL %s_busy dut%0d got %0d required %0d", name, d, busy, nib_of(d) + 2);
    end
    checks++;
    if (ov[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s_release dut%0d out_valid got %b required 0", name, d, ov[d]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || get_s(d) !== 32'h0 || co[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got ir=%b ov=%b s=%h c=%b required 1 0 0 0",
                 d, ir[d], ov[d], get_s(d), co[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    check_op("basic_add", 0, 32'h1234, 32'h4321, 1'b0, 1'b0);
  endtask

  task automatic test_carry;
    check_op("ripple_a", 0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    check_op("ripple_b", 0, 32'hFFFF, 32'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub;
    check_op("sub_borrow", 0, 32'h0005, 32'h0007, 1'b1, 1'b1);
    check_op("sub_noborrow", 0, 32'h0007, 32'h0005, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    logic [31:0] hs;
    logic        hc;
    int          n;
    int          bad;
    n = 0;
    av[0] = 32'h8000; bv[0] = 32'h9001; ci[0] = 1'b1; sb[0] = 1'b0; ordy[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    av[0] = 32'h0F0F; bv[0] = 32'h0101;
    while (!ov[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    hs = get_s(0);
    hc = co[0];
    checks++;
    if (hs !== 32'h1002 || hc !== 1'b1) begin
      errors++;
      $display("FAIL bp_result got s=%h c=%b required 1002 1", hs, hc);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || get_s(0) !== hs || co[0] !== hc) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold unstable cycles got %0d required 0", bad);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || get_s(0) !== hs) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b s=%h required 1 0 %h", ir[0], ov[0], get_s(0), hs);
    end
    @(posedge clk); #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_single_handshake got ov=%b ir=%b required 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    check_op("pre_reset", 0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    av[0] = 32'h1111; bv[0] = 32'h2222; ci[0] = 1'b0; sb[0] = 1'b0; ordy[0] = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || s0 !== 16'h0 || co[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got ir=%b ov=%b s=%h c=%b required 1 0 0000 0", ir[0], ov[0], s0, co[0]);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_no_output got %0d valid cycles required 0", bad);
    end
    check_op("post_reset", 0, 32'h0001, 32'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_sweep;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mask;
    for (int d = 0; d < 3; d++) begin
      mask = (nib_of(d) == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * nib_of(d))) - 32'd1);
      for (int k = 0; k < 12; k++) begin
        ra = $urandom & mask;
        rb = $urandom & mask;
        check_op("sweep", d, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    check_op("edge8_max", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_op("edge1_sub", 1, 32'h0, 32'hF, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; ci[d] = 1'b0; sb[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    test_reset;
    test_basic;
    test_carry;
    test_sub;
    test_backpressure;
    test_reset_mid;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
